dtcore32_wb_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback sources.
  - Requester 0: the in-order pipeline writeback.
  - Requester 1: the long-latency multiply/divide unit.
- Registers the winning write onto the regfile write-port signals.
- Keeps a pending-write scoreboard for long-latency destinations so decode can stall on hazards.
- Sits between the WB stage / muldiv unit and dtcore32_regfile.

---
 rtl/dtcore32_wb_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dtcore32_wb_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtcore32_wb_arbiter.sv
// -----------------------------------------------------------------------------
// dtcore32_wb_arbiter
//
// Shares the register file's single write port between two writeback sources:
//   requester 0 : in-order pipeline writeback (default priority)
//   requester 1 : long-latency multiply/divide unit
// The winning write is registered onto the regfile write-port signals one
// cycle after acceptance. A 32-entry pending-write scoreboard tracks
// destinations of issued long-latency ops, so decode can stall on hazards.
//
// Ports:
//   clk_i, rst_i                   clock, asynchronous active-high reset
//   wb0_valid_i/rd_i/data_i        pipeline writeback request
//   wb0_ready_o                    pipeline request accepted this cycle
//   wb1_valid_i/rd_i/data_i        muldiv writeback request
//   wb1_ready_o                    muldiv request accepted this cycle
//   issue_valid_i, issue_rd_i      long-latency op issued / its destination
//   src_reg_1_i, src_reg_2_i       decode source registers
//   src_1_busy_o, src_2_busy_o     source has a pending long-latency write
//   regfile_wr_en_o                registered write enable (never for x0)
//   dest_reg_o, reg_wr_data_o      registered write address / data
//
// Parameters:
//   STARVE_LIMIT  consecutive stalled-valid cycles of requester 1 before it
//                 overrides requester 0 (1..15)
// -----------------------------------------------------------------------------
module dtcore32_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        wb0_valid_i,
  input  logic [4:0]  wb0_rd_i,
  input  logic [31:0] wb0_data_i,
  output logic        wb0_ready_o,

  input  logic        wb1_valid_i,
  input  logic [4:0]  wb1_rd_i,
  input  logic [31:0] wb1_data_i,
  output logic        wb1_ready_o,

  input  logic        issue_valid_i,
  input  logic [4:0]  issue_rd_i,
  input  logic [4:0]  src_reg_1_i,
  input  logic [4:0]  src_reg_2_i,
  output logic        src_1_busy_o,
  output logic        src_2_busy_o,

  output logic        regfile_wr_en_o,
  output logic [4:0]  dest_reg_o,
  output logic [31:0] reg_wr_data_o
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic        starved;
  logic        grant0;
  logic        grant1;
  logic        xfer0;
  logic        xfer1;
  logic [31:0] pending;
  logic [31:0] pending_next;

  // ---------------------------------------------------------------------------
  // Arbitration. Requester 0 wins by default; requester 1 wins when it is the
  // only one asking, or once it has waited STARVE_LIMIT consecutive cycles.
  // A grant implies the requester is valid, so ready never rises on an idle
  // requester. Both readies are forced low while reset is asserted so nothing
  // is accepted into a register that is being cleared.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    starved = 1'b0;
    grant0  = 1'b0;
    grant1  = 1'b0;

    starved = (starve_cnt == STARVE_MAX);
    grant1  = wb1_valid_i && (starved || !wb0_valid_i);
    grant0  = wb0_valid_i && !grant1;
  end

  assign wb0_ready_o = grant0 && !rst_i;
  assign wb1_ready_o = grant1 && !rst_i;

  assign xfer0 = wb0_valid_i && wb0_ready_o;
  assign xfer1 = wb1_valid_i && wb1_ready_o;

  // ---------------------------------------------------------------------------
  // Write-port register. Address and data are only loaded on a transfer and
  // hold otherwise; the enable is a one-cycle pulse, suppressed for x0 so a
  // write to x0 is still consumed (ready=1) but never reaches the regfile.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      regfile_wr_en_o <= 1'b0;
      dest_reg_o      <= 5'd0;
      reg_wr_data_o   <= 32'd0;
    end else if (xfer0) begin
      regfile_wr_en_o <= (wb0_rd_i != 5'd0);
      dest_reg_o      <= wb0_rd_i;
      reg_wr_data_o   <= wb0_data_i;
    end else if (xfer1) begin
      regfile_wr_en_o <= (wb1_rd_i != 5'd0);
      dest_reg_o      <= wb1_rd_i;
      reg_wr_data_o   <= wb1_data_i;
    end else begin
      regfile_wr_en_o <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation counter: counts consecutive cycles requester 1 is valid but not
  // accepted. Once it equals STARVE_LIMIT requester 1 wins the next arbitration,
  // so the saturation branch only guards against an unexpected hold.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt <= 4'd0;
    end else if (wb1_valid_i && !wb1_ready_o) begin
      if (starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= 4'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-write scoreboard. Clear is applied before set so that a register
  // issued in the same cycle its older write retires stays marked busy. Bit 0
  // is forced low: x0 never has a pending write.
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_next = pending;
    if (xfer1) begin
      pending_next[wb1_rd_i] = 1'b0;
    end
    if (issue_valid_i && (issue_rd_i != 5'd0)) begin
      pending_next[issue_rd_i] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: the scoreboard is flop-based control state, not a RAM, so it is
    // reset; a stale bit after reset would stall decode forever.
    if (rst_i) begin
      pending <= 32'd0;
    end else begin
      pending <= pending_next;
    end
  end

  // Busy reads the registered scoreboard, so a retiring write still reads busy
  // in its acceptance cycle and clears in the cycle the regfile is written.
  assign src_1_busy_o = pending[src_reg_1_i];
  assign src_2_busy_o = pending[src_reg_2_i];

`ifndef SYNTHESIS
  a_one_grant : assert property (@(posedge clk_i) disable iff (rst_i)
    !(wb0_ready_o && wb1_ready_o));
  a_ready_needs_valid : assert property (@(posedge clk_i) disable iff (rst_i)
    (!wb0_ready_o || wb0_valid_i) && (!wb1_ready_o || wb1_valid_i));
  a_x0_never_busy : assert property (@(posedge clk_i) disable iff (rst_i)
    !pending[0]);
`endif

endmodule

// File: tb/tb_dtcore32_wb_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for dtcore32_wb_arbiter.
// A driver applies directed and randomized stimulus at the falling edge and,
// from a behavioural model of the arbitration rules, pushes the expected
// combinational response (readies, busy flags) and the expected write-port
// contents after the next rising edge into two queues. Independent monitor
// processes pop and compare those whenever the DUT presents them.
// -----------------------------------------------------------------------------
module tb_dtcore32_wb_arbiter;

  localparam int unsigned STARVE_LIMIT = 4;
  localparam int          RANDOM_CYCLES = 3000;

  logic        clk_i;
  logic        rst_i;
  logic        wb0_valid_i;
  logic [4:0]  wb0_rd_i;
  logic [31:0] wb0_data_i;
  logic        wb0_ready_o;
  logic        wb1_valid_i;
  logic [4:0]  wb1_rd_i;
  logic [31:0] wb1_data_i;
  logic        wb1_ready_o;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;
  logic [4:0]  src_reg_1_i;
  logic [4:0]  src_reg_2_i;
  logic        src_1_busy_o;
  logic        src_2_busy_o;
  logic        regfile_wr_en_o;
  logic [4:0]  dest_reg_o;
  logic [31:0] reg_wr_data_o;

  dtcore32_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .wb0_valid_i     (wb0_valid_i),
    .wb0_rd_i        (wb0_rd_i),
    .wb0_data_i      (wb0_data_i),
    .wb0_ready_o     (wb0_ready_o),
    .wb1_valid_i     (wb1_valid_i),
    .wb1_rd_i        (wb1_rd_i),
    .wb1_data_i      (wb1_data_i),
    .wb1_ready_o     (wb1_ready_o),
    .issue_valid_i   (issue_valid_i),
    .issue_rd_i      (issue_rd_i),
    .src_reg_1_i     (src_reg_1_i),
    .src_reg_2_i     (src_reg_2_i),
    .src_1_busy_o    (src_1_busy_o),
    .src_2_busy_o    (src_2_busy_o),
    .regfile_wr_en_o (regfile_wr_en_o),
    .dest_reg_o      (dest_reg_o),
    .reg_wr_data_o   (reg_wr_data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------------------------------------------------------------------
  // Scoreboard queues and counters
  // ---------------------------------------------------------------------------
  typedef struct {
    logic ready0;
    logic ready1;
    logic busy1;
    logic busy2;
  } comb_exp_t;

  typedef struct {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
  } port_exp_t;

  comb_exp_t exp_comb[$];
  port_exp_t exp_port[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: how many cycles wb1 has been left waiting, which
  // registers have an outstanding long-latency write, and what the write port
  // last held.
  // ---------------------------------------------------------------------------
  int          m_waited;
  bit          m_pending[32];
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  task automatic model_reset();
    m_waited = 0;
    foreach (m_pending[i]) m_pending[i] = 1'b0;
    m_rd   = 5'd0;
    m_data = 32'd0;
  endtask

  task automatic idle_inputs();
    wb0_valid_i   = 1'b0;
    wb0_rd_i      = 5'd0;
    wb0_data_i    = 32'd0;
    wb1_valid_i   = 1'b0;
    wb1_rd_i      = 5'd0;
    wb1_data_i    = 32'd0;
    issue_valid_i = 1'b0;
    issue_rd_i    = 5'd0;
    src_reg_1_i   = 5'd0;
    src_reg_2_i   = 5'd0;
  endtask

  // One clock cycle of stimulus: apply inputs at the falling edge, predict the
  // response from the model, queue the predictions, then advance the model.
  task automatic drive_cycle(
    input  logic        v0, input logic [4:0] r0, input logic [31:0] d0,
    input  logic        v1, input logic [4:0] r1, input logic [31:0] d1,
    input  logic        iv, input logic [4:0] ir,
    input  logic [4:0]  s1, input logic [4:0] s2,
    output logic        g0, output logic g1);
    logic en;
    @(negedge clk_i);
    wb0_valid_i   = v0;
    wb0_rd_i      = r0;
    wb0_data_i    = d0;
    wb1_valid_i   = v1;
    wb1_rd_i      = r1;
    wb1_data_i    = d1;
    issue_valid_i = iv;
    issue_rd_i    = ir;
    src_reg_1_i   = s1;
    src_reg_2_i   = s2;
    #1;
    g1 = v1 && (!v0 || m_waited >= int'(STARVE_LIMIT));
    g0 = v0 && !g1;
    exp_comb.push_back('{g0, g1, m_pending[s1], m_pending[s2]});
    en = 1'b0;
    if (g0) begin
      m_rd = r0; m_data = d0; en = (r0 != 5'd0);
    end else if (g1) begin
      m_rd = r1; m_data = d1; en = (r1 != 5'd0);
    end
    exp_port.push_back('{en, m_rd, m_data});
    m_waited = (v1 && !g1) ? m_waited + 1 : 0;
    if (g1) m_pending[r1] = 1'b0;
    if (iv && ir != 5'd0) m_pending[ir] = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      comb_exp_t e;
      @(negedge clk_i);
      #3;
      if (exp_comb.size() != 0) begin
        e = exp_comb.pop_front();
        check("wb0_ready", 32'(wb0_ready_o), 32'(e.ready0));
        check("wb1_ready", 32'(wb1_ready_o), 32'(e.ready1));
        check("src_1_busy", 32'(src_1_busy_o), 32'(e.busy1));
        check("src_2_busy", 32'(src_2_busy_o), 32'(e.busy2));
      end
    end
  end

  initial begin
    forever begin
      port_exp_t e;
      @(posedge clk_i);
      #1;
      if (exp_port.size() != 0) begin
        e = exp_port.pop_front();
        check("regfile_wr_en", 32'(regfile_wr_en_o), 32'(e.en));
        check("dest_reg", 32'(dest_reg_o), 32'(e.rd));
        check("reg_wr_data", reg_wr_data_o, e.data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wb0_ready"}, 32'(wb0_ready_o), 32'd0);
    check({tag, "_wb1_ready"}, 32'(wb1_ready_o), 32'd0);
    check({tag, "_wr_en"}, 32'(regfile_wr_en_o), 32'd0);
    check({tag, "_dest"}, 32'(dest_reg_o), 32'd0);
    check({tag, "_data"}, reg_wr_data_o, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  function automatic logic [4:0] pick_rd();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd7;
      2:       return 5'($urandom_range(0, 31));
      default: return 5'($urandom_range(1, 7));
    endcase
  endfunction

  initial begin
    logic        g0, g1;
    logic        a0, a1;
    logic [4:0]  r0, r1;
    logic [31:0] d0, d1;

    rst_i = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    check_reset_outputs("reset0");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // Single source write to x5.
    drive_cycle(1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0, g0, g1);
    drive_cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0, g0, g1);

    // Contention: wb1 held valid while wb0 presents a fresh write every cycle.
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1, 5'(10 + i), 32'h1000 + 32'(i), 1, 5'd9, 32'hCAFE_0009,
                  0, 5'd0, 5'd0, 5'd0, g0, g1);
      check($sformatf("contention_grant1_cycle%0d", i + 1), 32'(g1), (i == 4) ? 32'd1 : 32'd0);
    end
    drive_cycle(1, 5'd15, 32'h1005, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0, g0, g1);

    // wb1 write to x0: accepted, no enable, scoreboard untouched.
    drive_cycle(0, 5'd0, 32'd0, 1, 5'd0, 32'h1234, 0, 5'd0, 5'd0, 5'd0, g0, g1);
    drive_cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0, g0, g1);

    // Scoreboard: issue x7, observe busy, retire it, then set/clear collision.
    drive_cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd7, 5'd7, 5'd7, g0, g1);
    drive_cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd7, 5'd3, g0, g1);
    drive_cycle(0, 5'd0, 32'd0, 1, 5'd7, 32'h0000_0777, 0, 5'd0, 5'd7, 5'd7, g0, g1);
    drive_cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd7, 5'd7, 5'd7, g0, g1);
    drive_cycle(0, 5'd0, 32'd0, 1, 5'd7, 32'h0000_0778, 1, 5'd7, 5'd7, 5'd7, g0, g1);
    drive_cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd7, 5'd7, g0, g1);
    drive_cycle(0, 5'd0, 32'd0, 1, 5'd7, 32'h0000_0779, 0, 5'd0, 5'd7, 5'd7, g0, g1);
    drive_cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd7, 5'd7, g0, g1);

    // Issue to x0 never marks it busy.
    drive_cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd0, 5'd0, 5'd0, g0, g1);
    drive_cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0, g0, g1);

    // Asynchronous reset mid-cycle with both requesters valid.
    drive_cycle(1, 5'd4, 32'h4444, 1, 5'd6, 32'h6666, 1, 5'd6, 5'd6, 5'd4, g0, g1);
    @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    check_reset_outputs("reset_mid");
    model_reset();
    repeat (2) @(negedge clk_i);
    idle_inputs();
    rst_i = 1'b0;
    drive_cycle(1, 5'd12, 32'h0BAD_F00D, 0, 5'd0, 32'd0, 0, 5'd0, 5'd6, 5'd0, g0, g1);
    drive_cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0, g0, g1);

    // Randomized traffic; each requester holds its request until accepted.
    a0 = 1'b0; a1 = 1'b0;
    r0 = 5'd0; r1 = 5'd0; d0 = 32'd0; d1 = 32'd0;
    for (int c = 0; c < RANDOM_CYCLES; c++) begin
      if (!a0 && $urandom_range(0, 3) != 0) begin
        a0 = 1'b1; r0 = pick_rd(); d0 = $urandom();
      end
      if (!a1 && $urandom_range(0, 1) != 0) begin
        a1 = 1'b1; r1 = pick_rd(); d1 = $urandom();
      end
      drive_cycle(a0, a0 ? r0 : 5'd0, a0 ? d0 : 32'd0,
                  a1, a1 ? r1 : 5'd0, a1 ? d1 : 32'd0,
                  ($urandom_range(0, 2) == 0), pick_rd(), pick_rd(), pick_rd(), g0, g1);
      if (g0) a0 = 1'b0;
      if (g1) a1 = 1'b0;
    end
    drive_cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0, g0, g1);

    repeat (3) @(negedge clk_i);
    check("queues_drained", 32'(exp_comb.size() + exp_port.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
